// File: rtl/sensor_rr_scheduler.sv
// Round-robin scheduler granting one of 8 sensors onto a shared {id, data} packet bus with a valid/ready handshake.
// Optional SEND-state timeout abort is compiled in when SCHED_TIMEOUT_EN is defined.
module sensor_rr_scheduler #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear_err,
    input  logic [7:0]        sensor_req,
    input  logic [DATA_W-1:0] sensor_data0,
    input  logic [DATA_W-1:0] sensor_data1,
    input  logic [DATA_W-1:0] sensor_data2,
    input  logic [DATA_W-1:0] sensor_data3,
    input  logic [DATA_W-1:0] sensor_data4,
    input  logic [DATA_W-1:0] sensor_data5,
    input  logic [DATA_W-1:0] sensor_data6,
    input  logic [DATA_W-1:0] sensor_data7,
    output logic [7:0]        sensor_ack,
    output logic [DATA_W+2:0] packet_out,
    output logic              packet_valid,
    input  logic              packet_ready,
    output logic              error
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [DATA_W+2:0]   packet_out_q, packet_out_d;
    logic [7:0]          sensor_ack_q, sensor_ack_d;
    logic                error_q, error_d;

    logic [DATA_W-1:0]   sensor_data_arr [8];
    logic                grant_found;
    logic [2:0]          grant_idx;
    logic                start_grant, abort, xfer, timeout;

    assign sensor_data_arr[0] = sensor_data0;
    assign sensor_data_arr[1] = sensor_data1;
    assign sensor_data_arr[2] = sensor_data2;
    assign sensor_data_arr[3] = sensor_data3;
    assign sensor_data_arr[4] = sensor_data4;
    assign sensor_data_arr[5] = sensor_data5;
    assign sensor_data_arr[6] = sensor_data6;
    assign sensor_data_arr[7] = sensor_data7;

    // Rotating priority: first requester at or above rr_ptr, wrapping through 7 -> 0.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] cand;
            cand = rr_ptr_q + 3'(i);
            if (!grant_found && sensor_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts SEND cycles already completed; the last allowed cycle ends in abort.
    assign timeout = (state_q == SEND) && enable && !packet_ready &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == SEND && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Abort on enable=0 has priority over a simultaneous ready.
    assign start_grant = (state_q == IDLE) && enable && grant_found;
    assign abort       = (state_q == SEND) && !enable;
    assign xfer        = (state_q == SEND) && enable && packet_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_grant)                state_d = SEND;
            SEND: if (abort || xfer || timeout)   state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        packet_out_d = packet_out_q;
        sensor_ack_d = '0;
        error_d      = error_q;
        if (start_grant) begin
            rr_ptr_d                = grant_idx + 3'd1;
            packet_out_d            = {grant_idx, sensor_data_arr[grant_idx]};
            sensor_ack_d[grant_idx] = 1'b1;
        end
        // A set event in the same cycle as clear_err leaves the flag set.
        if (clear_err) begin
            error_d = 1'b0;
        end
        if (abort || timeout) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            packet_out_q <= '0;
            sensor_ack_q <= '0;
            error_q      <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            packet_out_q <= packet_out_d;
            sensor_ack_q <= sensor_ack_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        packet_valid = (state_q == SEND);
        packet_out   = packet_out_q;
        sensor_ack   = sensor_ack_q;
        error        = error_q;
    end

endmodule

// File: tb/tb_sensor_rr_scheduler.sv
// Directed self-checking bench for sensor_rr_scheduler: reset, single grant, round-robin,
// backpressure, abort/error handling, wrap/skip and mid-SEND reset.
module tb_sensor_rr_scheduler;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst, enable, clear_err, packet_ready;
    logic [7:0]        sensor_req;
    logic [DATA_W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0]        sensor_ack;
    logic [DATA_W+2:0] packet_out;
    logic              packet_valid, error;

    int checks = 0;
    int errors = 0;

    logic [7:0] dtab [8];

    always #5 clk = ~clk;

    sensor_rr_scheduler #(.DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
        .sensor_req(sensor_req),
        .sensor_data0(d0), .sensor_data1(d1), .sensor_data2(d2), .sensor_data3(d3),
        .sensor_data4(d4), .sensor_data5(d5), .sensor_data6(d6), .sensor_data7(d7),
        .sensor_ack(sensor_ack), .packet_out(packet_out), .packet_valid(packet_valid),
        .packet_ready(packet_ready), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] ack, input logic valid,
                             input logic [10:0] pkt, input logic err);
        check({tag, ".ack"},   32'(sensor_ack),   32'(ack));
        check({tag, ".valid"}, 32'(packet_valid), 32'(valid));
        check({tag, ".pkt"},   32'(packet_out),   32'(pkt));
        check({tag, ".err"},   32'(error),        32'(err));
    endtask

    initial begin
        dtab[0] = 8'hAA; dtab[1] = 8'h11; dtab[2] = 8'h22; dtab[3] = 8'h0F;
        dtab[4] = 8'h44; dtab[5] = 8'h55; dtab[6] = 8'h77; dtab[7] = 8'h66;
        d0 = dtab[0]; d1 = dtab[1]; d2 = dtab[2]; d3 = dtab[3];
        d4 = dtab[4]; d5 = dtab[5]; d6 = dtab[6]; d7 = dtab[7];
        rst = 1'b1; enable = 1'b1; clear_err = 1'b0; packet_ready = 1'b0; sensor_req = 8'h00;

        // 1. Reset
        step(); step();
        check_all("reset", 8'h00, 1'b0, 11'h000, 1'b0);
        rst = 1'b0;
        step();
        check_all("idle_noreq", 8'h00, 1'b0, 11'h000, 1'b0);

        // 2. Single request, immediate transfer
        sensor_req = 8'h01; packet_ready = 1'b1;
        step();
        check_all("single_grant", 8'h01, 1'b1, 11'b000_10101010, 1'b0);
        sensor_req = 8'h00;
        step();
        check_all("single_xfer", 8'h00, 1'b0, 11'b000_10101010, 1'b0);

        // 3. Round-robin from rr_ptr=0 with all requests held
        rst = 1'b1; step(); rst = 1'b0;
        sensor_req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] g;
            g = 3'(k % 8);
            step();
            check_all($sformatf("rr_grant%0d", k), 8'(1 << g), 1'b1, {g, dtab[g]}, 1'b0);
            step();
            check($sformatf("rr_xfer%0d", k), 32'(packet_valid), 32'd0);
        end
        sensor_req = 8'h00;
        step();
        // rr_ptr is now 1.

        // 4. Backpressure on sensor3
        sensor_req = 8'h08; packet_ready = 1'b0;
        step();
        check_all("bp_grant", 8'h08, 1'b1, 11'b011_00001111, 1'b0);
        sensor_req = 8'h10;
        for (int k = 0; k < 4; k++) begin
            step();
            check_all($sformatf("bp_hold%0d", k), 8'h00, 1'b1, 11'b011_00001111, 1'b0);
        end
        packet_ready = 1'b1;
        step();
        check_all("bp_xfer", 8'h00, 1'b0, 11'b011_00001111, 1'b0);
        step();
        check_all("bp_next", 8'h10, 1'b1, {3'd4, 8'h44}, 1'b0);
        sensor_req = 8'h00;
        step();
        // rr_ptr is now 5.

        // 5. enable=0 in IDLE blocks grants
        sensor_req = 8'h01; enable = 1'b0;
        step();
        check_all("en0_idle", 8'h00, 1'b0, {3'd4, 8'h44}, 1'b0);
        enable = 1'b1;
        step();
        check_all("abort_grant", 8'h01, 1'b1, {3'd0, 8'hAA}, 1'b0);
        sensor_req = 8'h00; enable = 1'b0; packet_ready = 1'b1;
        step();
        check_all("abort", 8'h00, 1'b0, {3'd0, 8'hAA}, 1'b1);
        enable = 1'b1;
        step();
        check("err_sticky", 32'(error), 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("err_clear", 32'(error), 32'd0);
        // Set and clear in the same cycle: set wins.
        sensor_req = 8'h04;
        step();
        check("abort2_ack", 32'(sensor_ack), 32'h04);
        sensor_req = 8'h00; enable = 1'b0; clear_err = 1'b1;
        step();
        check("set_vs_clear", 32'(error), 32'd1);
        check("set_vs_clear.valid", 32'(packet_valid), 32'd0);
        enable = 1'b1;
        step();
        clear_err = 1'b0;
        check("err_clear2", 32'(error), 32'd0);

`ifdef SCHED_TIMEOUT_EN
        sensor_req = 8'h02; packet_ready = 1'b0;
        step();
        check("to_grant", 32'(sensor_ack), 32'h02);
        sensor_req = 8'h00;
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("to_wait%0d", k), 32'(packet_valid), 32'd1);
        end
        step();
        check("to_abort.valid", 32'(packet_valid), 32'd0);
        check("to_abort.err", 32'(error), 32'd1);
        clear_err = 1'b1; packet_ready = 1'b1;
        step();
        clear_err = 1'b0;
`endif

        // 6. Wrap and skip from rr_ptr=6
        rst = 1'b1; step(); rst = 1'b0;
        packet_ready = 1'b1;
        sensor_req = 8'h20;
        step();
        check("wrap_setup", 32'(sensor_ack), 32'h20);
        sensor_req = 8'h00;
        step();
        sensor_req = 8'h22;
        step();
        check_all("wrap_g1", 8'h02, 1'b1, {3'd1, 8'h11}, 1'b0);
        sensor_req = 8'h20;
        step();
        check("wrap_x1", 32'(packet_valid), 32'd0);
        step();
        check_all("wrap_g5", 8'h20, 1'b1, {3'd5, 8'h55}, 1'b0);
        packet_ready = 1'b0;
        rst = 1'b1;
        step();
        check_all("mid_send_rst", 8'h00, 1'b0, 11'h000, 1'b0);
        rst = 1'b0; sensor_req = 8'h00;
        step();
        check_all("post_rst", 8'h00, 1'b0, 11'h000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
